etroc1_l1_sched: RTL and testbench

Trigger-queue and readout scheduler for the ETROC1 4x4 pixel array. It keeps the BX write pointer for the 16 pixel RAMs and converts each L1acc into a look-back RAM address. Accepted triggers are queued, and the scheduler then streams a framed event (header, ROI-selected pixel words, trailer) onto the 30-bit output bus by time-sharing the RAM address and the row output enables. It sits between the pixel RAM array with its column buses and the serializer, and it replaces direct single-trigger sequencing.

---
 rtl/etroc1_pkg.sv | 57 +++++
 rtl/etroc1_trig_fifo.sv | 50 +++++
 rtl/etroc1_l1_sched.sv | 142 ++++++++++++++
 tb/tb_etroc1_l1_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/etroc1_pkg.sv
// Shared types and helpers for the ETROC1 L1 trigger scheduler.
package etroc1_pkg;

    localparam int WORD_W    = 30;
    localparam int HDR_PAD_W = 14;
    localparam int TRL_PAD_W = 25;

    typedef enum logic [1:0] {
        DT_IDLE = 2'b00,
        DT_HDR  = 2'b01,
        DT_DATA = 2'b10,
        DT_TRL  = 2'b11
    } dtype_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_SCAN,
        S_TRL
    } state_e;

    // One queued trigger: event counter and look-back RAM address.
    typedef struct packed {
        logic [7:0] l1cnt;
        logic [7:0] rdaddr;
    } trig_t;

    function automatic logic [4:0] popcount16(input logic [15:0] m);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'b0000, m[i]};
        end
        return n;
    endfunction

    // Lowest set index of the remaining mask (0 when the mask is empty).
    function automatic logic [3:0] first_set(input logic [15:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [WORD_W-1:0] make_header(input trig_t t);
        return {{HDR_PAD_W{1'b0}}, t.l1cnt, t.rdaddr};
    endfunction

    function automatic logic [WORD_W-1:0] make_trailer(input logic [4:0] npix);
        return {{TRL_PAD_W{1'b0}}, npix};
    endfunction

endpackage

// File: rtl/etroc1_trig_fifo.sv
// Trigger FIFO: DEPTH entries of {l1cnt, rdaddr}; a push while full is
// accepted only when a pop happens in the same cycle.
module etroc1_trig_fifo
    import etroc1_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  push,
    input  trig_t wdata,
    input  logic  pop,
    output trig_t rdata,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    trig_t       mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB tells full from empty.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Entry storage.
    always_ff @(posedge clock) begin
        // NOTE: storage is not reset; the pointers alone define which entries are valid.
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/etroc1_l1_sched.sv
// ETROC1 L1 scheduler: BX write pointer, trigger queue and framed readout.
module etroc1_l1_sched
    import etroc1_pkg::*;
#(
    parameter int L1_LATENCY = 100,
    parameter int TRIG_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        l1acc,
    input  logic        bc0,
    input  logic [15:0] roi,
    input  logic [29:0] din0,
    input  logic [29:0] din1,
    input  logic [29:0] din2,
    input  logic [29:0] din3,
    output logic        we,
    output logic [7:0]  addr,
    output logic [3:0]  roe,
    output logic [29:0] dout,
    output logic [1:0]  dtype,
    output logic        busy,
    output logic        overflow
);

    localparam logic [7:0] LAT8 = 8'(L1_LATENCY);

    logic [7:0]  bcid;
    logic [7:0]  l1cnt;
    state_e      state;
    trig_t       ev;
    logic [15:0] mask_rem;
    logic [4:0]  npix;
    logic [29:0] dout_q;
    dtype_e      dtype_q;

    trig_t       push_entry;
    trig_t       fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        scanning;
    logic [3:0]  cur_idx;
    logic [15:0] mask_next;
    logic [29:0] col_word;

    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign push_entry = {l1cnt, bcid - LAT8};
    assign scanning   = (state == S_SCAN);
    assign cur_idx    = first_set(mask_rem);
    assign mask_next  = mask_rem & ~(16'd1 << cur_idx);

    etroc1_trig_fifo #(
        .DEPTH(TRIG_DEPTH)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (l1acc),
        .wdata(push_entry),
        .pop  (pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // BX counter, trigger counter and sticky drop flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bcid     <= '0;
            l1cnt    <= '0;
            overflow <= 1'b0;
        end else begin
            bcid <= bc0 ? 8'd0 : bcid + 8'd1;
            if (l1acc) l1cnt <= l1cnt + 8'd1;
            if (l1acc && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    // Event framing FSM with registered output word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ev       <= '0;
            mask_rem <= '0;
            npix     <= '0;
            dout_q   <= '0;
            dtype_q  <= DT_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    dout_q  <= '0;
                    dtype_q <= DT_IDLE;
                    if (!fifo_empty) begin
                        ev       <= fifo_rdata;
                        mask_rem <= roi;
                        npix     <= popcount16(roi);
                        state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    dout_q  <= make_header(ev);
                    dtype_q <= DT_HDR;
                    state   <= (mask_rem != 16'd0) ? S_SCAN : S_TRL;
                end
                S_SCAN: begin
                    dout_q   <= col_word;
                    dtype_q  <= DT_DATA;
                    mask_rem <= mask_next;
                    if (mask_next == 16'd0) state <= S_TRL;
                end
                S_TRL: begin
                    dout_q  <= make_trailer(npix);
                    dtype_q <= DT_TRL;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Column bus select for the pixel being read this cycle.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        col_word = din0;
        case (cur_idx[1:0])
            2'd0: col_word = din0;
            2'd1: col_word = din1;
            2'd2: col_word = din2;
            2'd3: col_word = din3;
            default: col_word = din0;
        endcase
    end

    // RAM side: write at bcid except while scanning, when the latched read address is driven.
    assign we    = !reset && !scanning;
    assign addr  = scanning ? ev.rdaddr : bcid;
    assign roe   = scanning ? (4'b0001 << cur_idx[3:2]) : 4'b0000;
    assign busy  = (state != S_IDLE) || !fifo_empty;
    assign dout  = dout_q;
    assign dtype = dtype_q;

endmodule

// File: tb/tb_etroc1_l1_sched.sv
// Self-checking bench for etroc1_l1_sched: directed vector table, corner
// sequences and random triggers against a queue-based event model.
module tb_etroc1_l1_sched;

    localparam int LAT   = 100;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        l1acc;
    logic        bc0;
    logic [15:0] roi;
    logic [29:0] din0, din1, din2, din3;
    logic        we;
    logic [7:0]  addr;
    logic [3:0]  roe;
    logic [29:0] dout;
    logic [1:0]  dtype;
    logic        busy;
    logic        overflow;

    etroc1_l1_sched #(
        .L1_LATENCY(LAT),
        .TRIG_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .l1acc(l1acc), .bc0(bc0), .roi(roi),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .we(we), .addr(addr), .roe(roe), .dout(dout), .dtype(dtype),
        .busy(busy), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;

    // Pixel word stored by pixel p at RAM address a.
    function automatic logic [29:0] pix_word(input int p, input logic [7:0] a);
        logic [15:0] mix;
        mix = 16'(p * 4099 + int'(a) * 77);
        return {2'b01, p[3:0], a, mix};
    endfunction

    // Bench-side pixel RAM array: an address holds data once it has been written.
    bit ram_ok [256];

    always_comb begin
        int r;
        r = -1;
        case (roe)
            4'b0001: r = 0;
            4'b0010: r = 1;
            4'b0100: r = 2;
            4'b1000: r = 3;
            default: r = -1;
        endcase
        din0 = '0; din1 = '0; din2 = '0; din3 = '0;
        if (r >= 0 && ram_ok[addr]) begin
            din0 = pix_word(r * 4 + 0, addr);
            din1 = pix_word(r * 4 + 1, addr);
            din2 = pix_word(r * 4 + 2, addr);
            din3 = pix_word(r * 4 + 3, addr);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] rdaddr;
        logic [7:0] l1cnt;
    } trig_s;

    typedef struct {
        logic [1:0]  t;
        logic [29:0] d;
        int          pix;
        logic [7:0]  ra;
    } word_s;

    trig_s       mq [$];
    word_s       exp_word [int];
    logic [7:0]  scan_addr [int];
    logic [3:0]  scan_roe [int];
    bit          written [256];
    int          cyc, free_at, busy_until;
    logic [7:0]  m_bcid, m_l1cnt;
    bit          m_ovf;

    logic        e_we, e_busy, e_ovf;
    logic [7:0]  e_addr;
    logic [3:0]  e_roe;
    logic [1:0]  e_dtype;
    logic [29:0] e_dout;
    logic [1:0]  s_dtype;
    logic [29:0] s_dout;

    task automatic model_reset();
        cyc = 0; free_at = 0; busy_until = -1;
        m_bcid = 8'd0; m_l1cnt = 8'd0; m_ovf = 1'b0;
        mq.delete(); exp_word.delete(); scan_addr.delete(); scan_roe.delete();
        s_dtype = 2'b00; s_dout = '0;
    endtask

    // Expected outputs for the current cycle, then the effect of this cycle's inputs.
    task automatic model_cycle();
        word_s w;
        trig_s e;
        int    n;
        if (exp_word.exists(cyc)) begin
            w = exp_word[cyc];
            exp_word.delete(cyc);
            e_dtype = w.t;
            e_dout  = (w.pix >= 0) ? (written[w.ra] ? pix_word(w.pix, w.ra) : 30'd0) : w.d;
        end else begin
            e_dtype = 2'b00;
            e_dout  = '0;
        end
        if (scan_roe.exists(cyc)) begin
            e_we = 1'b0; e_addr = scan_addr[cyc]; e_roe = scan_roe[cyc];
            scan_addr.delete(cyc); scan_roe.delete(cyc);
        end else begin
            e_we = 1'b1; e_addr = m_bcid; e_roe = 4'b0000;
        end
        e_busy = (mq.size() != 0) || (cyc <= busy_until);
        e_ovf  = m_ovf;
        if (mq.size() != 0 && cyc >= free_at) begin
            e = mq.pop_front();
            n = 0;
            exp_word[cyc + 2] = '{2'b01, {14'd0, e.l1cnt, e.rdaddr}, -1, 8'd0};
            for (int p = 0; p < 16; p++) begin
                if (roi[p]) begin
                    n++;
                    scan_addr[cyc + 1 + n] = e.rdaddr;
                    scan_roe[cyc + 1 + n]  = 4'b0001 << (p / 4);
                    exp_word[cyc + 2 + n]  = '{2'b10, 30'd0, p, e.rdaddr};
                end
            end
            exp_word[cyc + 3 + n] = '{2'b11, 30'(n), -1, 8'd0};
            busy_until = cyc + 2 + n;
            free_at    = cyc + 3 + n;
        end
        if (l1acc) begin
            if (mq.size() < DEPTH) mq.push_back('{m_bcid - 8'(LAT), m_l1cnt});
            else m_ovf = 1'b1;
            m_l1cnt = m_l1cnt + 8'd1;
        end
        if (e_we) written[m_bcid] = 1'b1;
        m_bcid = bc0 ? 8'd0 : m_bcid + 8'd1;
    endtask

    // One clock: drive inputs, predict, compare mid-cycle, commit RAM write, advance.
    task automatic step(input bit l1, input bit b0, input logic [15:0] r);
        l1acc = l1; bc0 = b0; roi = r;
        model_cycle();
        @(negedge clock);
        check("dtype", dtype, e_dtype);
        check("dout", dout, e_dout);
        check("we", we, e_we);
        check("addr", addr, e_addr);
        check("roe", roe, e_roe);
        check("busy", busy, e_busy);
        check("overflow", overflow, e_ovf);
        s_dtype = dtype;
        s_dout  = dout;
        if (we) ram_ok[addr] = 1'b1;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check_reset_vals();
        check("rst_dout", dout, 0);
        check("rst_dtype", dtype, 0);
        check("rst_we", we, 0);
        check("rst_addr", addr, 0);
        check("rst_roe", roe, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; l1acc = 1'b0; bc0 = 1'b0;
        #1;
        check_reset_vals();
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        for (int k = 0; k < 500 && (mq.size() != 0 || cyc <= busy_until + 2); k++) step(0, 0, 16'h0);
        check("drain_idle", busy, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [15:0] roi;
        logic [7:0]  bcid;
        logic [7:0]  rdaddr;
        logic [7:0]  l1cnt;
        int          npix;
        int          first_pix;
    } vec_s;

    vec_s vt [6];

    task automatic run_vec(input vec_s v);
        int          lat, ndata;
        bit          got_hdr, got_trl;
        logic [29:0] hdr, first, trl;
        lat = 0; ndata = 0; got_hdr = 0; got_trl = 0;
        hdr = '0; first = '0; trl = '0;
        for (int k = 0; k < 600 && m_bcid != v.bcid; k++) step(0, 0, 16'h0);
        step(1, 0, v.roi);
        // roi is held through the pop cycle, then cleared to show it is latched
        for (int k = 1; k <= 40 && !got_trl; k++) begin
            step(0, 0, (k == 1) ? v.roi : 16'h0);
            if (s_dtype == 2'b01 && !got_hdr) begin
                got_hdr = 1; lat = k; hdr = s_dout;
            end else if (s_dtype == 2'b10) begin
                if (ndata == 0) first = s_dout;
                ndata++;
            end else if (s_dtype == 2'b11) begin
                got_trl = 1; trl = s_dout;
            end
        end
        check("vec_trailer_seen", got_trl, 1);
        check("vec_hdr_latency", lat, 3);
        check("vec_header", hdr, {14'd0, v.l1cnt, v.rdaddr});
        check("vec_ndata", ndata, v.npix);
        check("vec_trailer", trl, v.npix);
        if (v.npix > 0) check("vec_first_data", first, pix_word(v.first_pix, v.rdaddr));
    endtask

    function automatic logic [15:0] rand_roi();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        vt[0] = '{16'h8001, 8'd150, 8'd50,  8'd0, 2,  0};
        vt[1] = '{16'h0001, 8'd20,  8'd176, 8'd1, 1,  0};
        vt[2] = '{16'h0000, 8'd200, 8'd100, 8'd2, 0,  0};
        vt[3] = '{16'hFFFF, 8'd99,  8'd255, 8'd3, 16, 0};
        vt[4] = '{16'h0420, 8'd100, 8'd0,   8'd4, 2,  5};
        vt[5] = '{16'h1000, 8'd250, 8'd150, 8'd5, 1,  12};

        for (int a = 0; a < 256; a++) begin
            ram_ok[a]  = 1'b0;
            written[a] = 1'b0;
        end
        reset = 1'b1; l1acc = 1'b0; bc0 = 1'b0; roi = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals();
        reset = 1'b0;
        model_reset();

        // bc0 then idle: write pointer runs and wraps, no events
        step(0, 1, 16'h0);
        repeat (299) step(0, 0, 16'h0);

        foreach (vt[i]) run_vec(vt[i]);
        drain();

        // six back-to-back triggers, then a late one that shows the l1cnt gap
        do_reset();
        repeat (6) step(1, 0, 16'hFFFF);
        repeat (30) step(0, 0, 16'hFFFF);
        step(1, 0, 16'hFFFF);
        drain();
        check("b2b_overflow", overflow, 1);

        // push into a full FIFO on the cycle it pops is accepted; one cycle later it is dropped
        do_reset();
        repeat (5) step(1, 0, 16'hFFFF);
        for (int k = 0; k < 40 && cyc < 20; k++) step(0, 0, 16'hFFFF);
        step(1, 0, 16'hFFFF);
        check("fullpop_no_overflow", overflow, 0);
        step(1, 0, 16'hFFFF);
        check("full_drop_overflow", overflow, 1);
        drain();

        // reset in the middle of a scan
        do_reset();
        step(1, 0, 16'hFFFF);
        for (int k = 0; k < 20 && s_dtype != 2'b10; k++) step(0, 0, 16'hFFFF);
        check("scan_reached", s_dtype, 2'b10);
        reset = 1'b1;
        #1;
        check_reset_vals();
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (30) step(0, 0, 16'h0);

        // random traffic
        repeat (3000) step($urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0, rand_roi());
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
